// File: rtl/acq_window_pkg.sv
// Shared types and constants for the acquisition window controller:
// FSM state encoding, register map offsets and register bit positions.
package acq_window_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RUNNING = 2'd2,
    ST_DONE    = 2'd3
  } acq_state_t;

  localparam logic [7:0] REG_CTRL     = 8'h00;
  localparam logic [7:0] REG_STATUS   = 8'h04;
  localparam logic [7:0] REG_CONFIG   = 8'h08;
  localparam logic [7:0] REG_NUM_RUNS = 8'h0C;
  localparam logic [7:0] REG_DUR_LO   = 8'h10;
  localparam logic [7:0] REG_DUR_HI   = 8'h14;
  localparam logic [7:0] REG_PASSED   = 8'h18;
  localparam logic [7:0] REG_DROPPED  = 8'h1C;

  localparam int CTRL_ARM_BIT   = 0;
  localparam int CTRL_ABORT_BIT = 1;
  localparam int CFG_CH_LSB     = 0;
  localparam int CFG_CH_MSB     = 4;
  localparam int CFG_RISING_BIT = 8;

  // Run counter increment that sticks at its maximum instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/wb_interface.sv
// Minimal single-beat Wishbone bus, 8-bit byte address, 32-bit data.
interface wb_interface;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [7:0]  adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport slave  (input cyc, stb, we, adr, dat_w, output dat_r, ack);
  modport master (output cyc, stb, we, adr, dat_w, input dat_r, ack);
endinterface

// File: rtl/acq_window_regs.sv
// Wishbone register file for the acquisition window controller.
// ack follows cyc&stb by one cycle; writes commit on the edge that raises
// ack. ARM/ABORT are combinational pulses valid on that same edge so the
// FSM reacts at the commit edge.
module acq_window_regs
  import acq_window_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  wb_interface.slave  wb,
  input  acq_state_t  i_state,
  input  logic [15:0] i_runs_done,
  input  logic [31:0] i_passed,
  input  logic [31:0] i_dropped,
  output logic        o_arm,
  output logic        o_abort,
  output logic [4:0]  o_start_channel,
  output logic        o_start_rising,
  output logic [15:0] o_num_runs,
  output logic [63:0] o_duration
);

  logic        r_ack;
  logic [31:0] r_rdata;
  logic [4:0]  r_start_channel;
  logic        r_start_rising;
  logic [15:0] r_num_runs;
  logic [63:0] r_duration;
  logic        w_req;
  logic        w_wr;
  logic [31:0] w_rdata;

  assign w_req   = wb.cyc & wb.stb & ~r_ack;
  assign w_wr    = w_req & wb.we;
  assign o_arm   = w_wr && (wb.adr == REG_CTRL) && wb.dat_w[CTRL_ARM_BIT];
  assign o_abort = w_wr && (wb.adr == REG_CTRL) && wb.dat_w[CTRL_ABORT_BIT];

  assign wb.ack   = r_ack;
  assign wb.dat_r = r_rdata;

  assign o_start_channel = r_start_channel;
  assign o_start_rising  = r_start_rising;
  assign o_num_runs      = r_num_runs;
  assign o_duration      = r_duration;

  // Read data mux; unmapped and write-only addresses read as zero.
  always_comb begin
    w_rdata = '0;
    case (wb.adr)
      REG_STATUS:   w_rdata = {i_runs_done, 14'd0, i_state};
      REG_CONFIG: begin
        w_rdata[CFG_CH_MSB:CFG_CH_LSB] = r_start_channel;
        w_rdata[CFG_RISING_BIT]        = r_start_rising;
      end
      REG_NUM_RUNS: w_rdata[15:0] = r_num_runs;
      REG_DUR_LO:   w_rdata = r_duration[31:0];
      REG_DUR_HI:   w_rdata = r_duration[63:32];
      REG_PASSED:   w_rdata = i_passed;
      REG_DROPPED:  w_rdata = i_dropped;
      default:      w_rdata = '0;
    endcase
  end

  // Zero-wait-state ack and registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= w_req;
      if (w_req) r_rdata <= w_rdata;
    end
  end

  // Configuration register writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_channel <= '0;
      r_start_rising  <= 1'b0;
      r_num_runs      <= '0;
      r_duration      <= '0;
    end else if (w_wr) begin
      case (wb.adr)
        REG_CONFIG: begin
          r_start_channel <= wb.dat_w[CFG_CH_MSB:CFG_CH_LSB];
          r_start_rising  <= wb.dat_w[CFG_RISING_BIT];
        end
        REG_NUM_RUNS: r_num_runs         <= wb.dat_w[15:0];
        REG_DUR_LO:   r_duration[31:0]   <= wb.dat_w;
        REG_DUR_HI:   r_duration[63:32]  <= wb.dat_w;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/acq_window_ctrl.sv
// Acquisition window controller: arms on a register command, triggers on a
// configured channel/edge, forwards only lanes inside [t_start, t_start+dur)
// (modulo 2^64) and repeats for NUM_RUNS windows.
// Optional feature macro: ACQ_WINDOW_STATS_EN adds PASSED/DROPPED counters.
// dbg_state mirrors the FSM state register.
module acq_window_ctrl
  import acq_window_pkg::*;
#(
  parameter int WORD_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [WORD_WIDTH-1:0][63:0] s_axis_tagtime,
  input  logic [WORD_WIDTH-1:0][4:0]  s_axis_channel,
  input  logic [WORD_WIDTH-1:0]       s_axis_rising_edge,
  input  logic [WORD_WIDTH-1:0]       s_axis_tkeep,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [WORD_WIDTH-1:0][63:0] m_axis_tagtime,
  output logic [WORD_WIDTH-1:0][4:0]  m_axis_channel,
  output logic [WORD_WIDTH-1:0]       m_axis_rising_edge,
  output logic [WORD_WIDTH-1:0]       m_axis_tkeep,
  wb_interface.slave                  wb,
  output logic                        acq_active,
  output logic                        run_done,
  output acq_state_t                  dbg_state
);

  // Stream handshake: a word moves when s_axis_tvalid && m_axis_tready.
  // Input ready is the output ready passed straight through; the output
  // stage only advances while m_axis_tready is high.

  acq_state_t                  r_state, w_next_state, w_end_state;
  logic [63:0]                 r_t_start, w_next_t_start;
  logic [63:0]                 r_dur, w_next_dur;
  logic [15:0]                 r_runs_done, w_next_runs, w_runs_inc;
  logic                        r_m_tvalid, r_run_done;
  logic [WORD_WIDTH-1:0][63:0] r_m_tagtime;
  logic [WORD_WIDTH-1:0][4:0]  r_m_channel;
  logic [WORD_WIDTH-1:0]       r_m_rising, r_m_tkeep;
  logic [WORD_WIDTH-1:0]       w_keep;
  logic                        w_accept, w_end, w_trig, w_arm, w_abort, w_arm_ok;
  logic [4:0]                  w_cfg_channel;
  logic                        w_cfg_rising;
  logic [15:0]                 w_num_runs;
  logic [63:0]                 w_cfg_dur;
  logic [31:0]                 w_passed_cnt, w_dropped_cnt;

  acq_window_regs u_regs (
    .clk             (clk),
    .rst             (rst),
    .wb              (wb),
    .i_state         (r_state),
    .i_runs_done     (r_runs_done),
    .i_passed        (w_passed_cnt),
    .i_dropped       (w_dropped_cnt),
    .o_arm           (w_arm),
    .o_abort         (w_abort),
    .o_start_channel (w_cfg_channel),
    .o_start_rising  (w_cfg_rising),
    .o_num_runs      (w_num_runs),
    .o_duration      (w_cfg_dur)
  );

  assign w_accept   = s_axis_tvalid & m_axis_tready;
  assign w_arm_ok   = w_arm & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_runs_inc = sat_inc16(r_runs_done);
  assign w_end_state = ((w_num_runs != 16'd0) && (w_runs_inc >= w_num_runs)) ? ST_DONE : ST_ARMED;

  // Next state and lane mask: walk the lanes in order, letting the state
  // evolve within the word (trigger opens the window, first late lane closes it).
  always_comb begin
    w_next_state   = r_state;
    w_next_t_start = r_t_start;
    w_next_dur     = r_dur;
    w_next_runs    = r_runs_done;
    w_keep         = '0;
    w_end          = 1'b0;
    w_trig         = 1'b0;
    if (w_accept) begin
      for (int i = 0; i < WORD_WIDTH; i++) begin
        if (s_axis_tkeep[i]) begin
          case (w_next_state)
            ST_ARMED: begin
              if (!w_trig && !w_end && (s_axis_channel[i] == w_cfg_channel) &&
                  (s_axis_rising_edge[i] == w_cfg_rising)) begin
                w_trig         = 1'b1;
                w_next_t_start = s_axis_tagtime[i];
                w_next_dur     = w_cfg_dur;
                if (w_cfg_dur == 64'd0) begin
                  w_end        = 1'b1;
                  w_next_state = w_end_state;
                end else begin
                  w_next_state = ST_RUNNING;
                  w_keep[i]    = 1'b1;
                end
              end
            end
            ST_RUNNING: begin
              if ((s_axis_tagtime[i] - w_next_t_start) < w_next_dur) begin
                w_keep[i] = 1'b1;
              end else begin
                w_end        = 1'b1;
                w_next_state = w_end_state;
              end
            end
            default: ;
          endcase
        end
      end
    end
    if (w_end) w_next_runs = w_runs_inc;
    if (w_abort) begin
      w_next_state = ST_IDLE;
    end else if (w_arm_ok) begin
      w_next_state = ST_ARMED;
      w_next_runs  = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Window bounds and run counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_t_start   <= '0;
      r_dur       <= '0;
      r_runs_done <= '0;
    end else begin
      r_t_start   <= w_next_t_start;
      r_dur       <= w_next_dur;
      r_runs_done <= w_next_runs;
    end
  end

  // One-cycle output stage holding the masked copy of the input word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_tvalid  <= 1'b0;
      r_m_tagtime <= '0;
      r_m_channel <= '0;
      r_m_rising  <= '0;
      r_m_tkeep   <= '0;
    end else if (m_axis_tready) begin
      r_m_tvalid  <= s_axis_tvalid;
      r_m_tagtime <= s_axis_tagtime;
      r_m_channel <= s_axis_channel;
      r_m_rising  <= s_axis_rising_edge;
      r_m_tkeep   <= w_keep;
    end
  end

  // run_done lines up with the output word that closed the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_run_done <= 1'b0;
    else     r_run_done <= w_end;
  end

`ifdef ACQ_WINDOW_STATS_EN
  logic [31:0] r_passed, r_dropped, w_pass_n, w_drop_n;

  // Count forwarded and masked valid lanes of each accepted word.
  always_comb begin
    w_pass_n = '0;
    w_drop_n = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (w_accept && s_axis_tkeep[i]) begin
        if (w_keep[i]) w_pass_n = w_pass_n + 32'd1;
        else           w_drop_n = w_drop_n + 32'd1;
      end
    end
  end

  // Wrapping statistics counters, cleared by an accepted ARM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_passed  <= '0;
      r_dropped <= '0;
    end else if (w_arm_ok) begin
      r_passed  <= '0;
      r_dropped <= '0;
    end else begin
      r_passed  <= r_passed + w_pass_n;
      r_dropped <= r_dropped + w_drop_n;
    end
  end

  assign w_passed_cnt  = r_passed;
  assign w_dropped_cnt = r_dropped;
`else
  assign w_passed_cnt  = '0;
  assign w_dropped_cnt = '0;
`endif

  assign s_axis_tready      = m_axis_tready;
  assign m_axis_tvalid      = r_m_tvalid;
  assign m_axis_tagtime     = r_m_tagtime;
  assign m_axis_channel     = r_m_channel;
  assign m_axis_rising_edge = r_m_rising;
  assign m_axis_tkeep       = r_m_tkeep;
  assign acq_active         = (r_state == ST_RUNNING);
  assign run_done           = r_run_done;
  assign dbg_state          = r_state;

endmodule

// File: tb/tb_acq_window_ctrl.sv
// Directed bench for acq_window_ctrl: a vector table for the main window
// sequence plus hand-written sequences for wrap, multi-run, abort,
// zero duration and asynchronous reset.
module tb_acq_window_ctrl;
  import acq_window_pkg::*;

  localparam int WW = 4;

  typedef logic [WW-1:0][63:0] tag_arr_t;
  typedef logic [WW-1:0][4:0]  ch_arr_t;

  typedef struct {
    logic       vld;
    tag_arr_t   tag;
    ch_arr_t    ch;
    logic [3:0] rise;
    logic [3:0] keep;
    logic [3:0] exp_keep;
    logic       exp_rd;
    logic [1:0] exp_state;
  } vec_t;

  // Clock/reset and DUT signals
  logic                clk = 1'b0;
  logic                rst;
  logic                s_axis_tvalid;
  logic                s_axis_tready;
  tag_arr_t            s_axis_tagtime;
  ch_arr_t             s_axis_channel;
  logic [WW-1:0]       s_axis_rising_edge;
  logic [WW-1:0]       s_axis_tkeep;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  tag_arr_t            m_axis_tagtime;
  ch_arr_t             m_axis_channel;
  logic [WW-1:0]       m_axis_rising_edge;
  logic [WW-1:0]       m_axis_tkeep;
  logic                acq_active;
  logic                run_done;
  acq_state_t          dbg_state;

  wb_interface wb_if ();

  int n_cmp = 0;
  int n_err = 0;
  logic [WW-1:0] exp_q[$];
  vec_t tbl[7];

  always #5 clk = ~clk;

  acq_window_ctrl #(.WORD_WIDTH(WW)) dut (
    .clk                (clk),
    .rst                (rst),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tready      (s_axis_tready),
    .s_axis_tagtime     (s_axis_tagtime),
    .s_axis_channel     (s_axis_channel),
    .s_axis_rising_edge (s_axis_rising_edge),
    .s_axis_tkeep       (s_axis_tkeep),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .m_axis_tagtime     (m_axis_tagtime),
    .m_axis_channel     (m_axis_channel),
    .m_axis_rising_edge (m_axis_rising_edge),
    .m_axis_tkeep       (m_axis_tkeep),
    .wb                 (wb_if),
    .acq_active         (acq_active),
    .run_done           (run_done),
    .dbg_state          (dbg_state)
  );

  function automatic tag_arr_t tags(input logic [63:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic ch_arr_t chs(input logic [4:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  // Scoreboard compare
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Driver: one Wishbone single-beat transfer, ack expected after one cycle
  task automatic wb_xfer(input logic we, input logic [7:0] adr, input logic [31:0] wdat,
                         output logic [31:0] rdat);
    int n;
    @(negedge clk);
    wb_if.cyc   = 1'b1;
    wb_if.stb   = 1'b1;
    wb_if.we    = we;
    wb_if.adr   = adr;
    wb_if.dat_w = wdat;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb_if.ack && n < 8);
    check($sformatf("wb_ack_cycles_%0h", adr), n, 1);
    rdat = wb_if.dat_r;
    wb_if.cyc = 1'b0;
    wb_if.stb = 1'b0;
    wb_if.we  = 1'b0;
  endtask

  task automatic wb_write(input logic [7:0] adr, input logic [31:0] wdat);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, wdat, dummy);
  endtask

  task automatic wb_read_check(input string name, input logic [7:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(1'b0, adr, 32'd0, rd);
    check(name, rd, exp);
  endtask

  // Driver: present one word for one cycle; returns at the negedge after
  // the capturing posedge, when the registered output shows that word.
  task automatic send_word(input logic vld, input tag_arr_t tag, input ch_arr_t ch,
                           input logic [3:0] rise, input logic [3:0] keep);
    @(negedge clk);
    s_axis_tvalid      = vld;
    s_axis_tagtime     = tag;
    s_axis_channel     = ch;
    s_axis_rising_edge = rise;
    s_axis_tkeep       = keep;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tkeep  = '0;
  endtask

  task automatic word_check(input string name, input logic [3:0] exp_keep,
                            input logic exp_rd, input logic [1:0] exp_state);
    check({name, "_tkeep"}, m_axis_tkeep, exp_keep);
    check({name, "_run_done"}, run_done, exp_rd);
    check({name, "_state"}, dbg_state, exp_state);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus and checks
  initial begin
    vec_t v;
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tagtime = '0;
    s_axis_channel = '0;
    s_axis_rising_edge = '0;
    s_axis_tkeep = '0;
    m_axis_tready = 1'b1;
    wb_if.cyc = 1'b0;
    wb_if.stb = 1'b0;
    wb_if.we = 1'b0;
    wb_if.adr = '0;
    wb_if.dat_w = '0;

    // Main window table: CONFIG ch2 rising, duration 1000, NUM_RUNS 2
    tbl[0] = '{1'b1, tags(4000, 4100, 0, 0), chs(2, 2, 0, 0), 4'b0010, 4'b0001, 4'b0000, 1'b0, 2'd1};
    tbl[1] = '{1'b0, tags(4200, 0, 0, 0), chs(2, 0, 0, 0), 4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd1};
    tbl[2] = '{1'b1, tags(5000, 0, 0, 0), chs(2, 0, 0, 0), 4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd2};
    tbl[3] = '{1'b1, tags(5500, 5999, 99999, 5200), chs(3, 0, 0, 1), 4'b0001, 4'b1011, 4'b1011, 1'b0, 2'd2};
    tbl[4] = '{1'b1, tags(6000, 6000, 0, 0), chs(1, 2, 0, 0), 4'b0010, 4'b0011, 4'b0000, 1'b1, 2'd1};
    tbl[5] = '{1'b1, tags(100, 200, 300, 1300), chs(0, 2, 1, 1), 4'b0010, 4'b1111, 4'b0110, 1'b1, 2'd3};
    tbl[6] = '{1'b1, tags(9000, 0, 0, 0), chs(2, 0, 0, 0), 4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd3};

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check("rst_m_tkeep", m_axis_tkeep, 4'b0000);
    check("rst_m_tagtime", m_axis_tagtime, '0);
    check("rst_acq_active", acq_active, 1'b0);
    check("rst_run_done", run_done, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    wb_read_check("rst_status", REG_STATUS, 32'h0);
    wb_read_check("rst_config", REG_CONFIG, 32'h0);

    // Backpressure freezes the output stage
    m_axis_tready = 1'b0;
    send_word(1'b1, tags(1, 0, 0, 0), chs(0, 0, 0, 0), 4'b1111, 4'b0001);
    check("bp_s_tready", s_axis_tready, 1'b0);
    check("bp_m_tvalid", m_axis_tvalid, 1'b0);
    m_axis_tready = 1'b1;
    check("bp_s_tready_on", s_axis_tready, 1'b1);

    // Valid word in IDLE: tvalid passes, lanes masked
    send_word(1'b1, tags(7, 0, 0, 0), chs(0, 0, 0, 0), 4'b0000, 4'b0001);
    check("idle_m_tvalid", m_axis_tvalid, 1'b1);
    check("idle_m_tkeep", m_axis_tkeep, 4'b0000);

    wb_write(REG_CONFIG, 32'h0000_0102);
    wb_read_check("cfg_readback", REG_CONFIG, 32'h0000_0102);
    wb_write(REG_DUR_LO, 32'd1000);
    wb_write(REG_DUR_HI, 32'd0);
    wb_write(REG_NUM_RUNS, 32'd2);
    wb_write(REG_CTRL, 32'h1);
    check("arm_state", dbg_state, ST_ARMED);

    for (int k = 0; k < 7; k++) begin
      v = tbl[k];
      exp_q.push_back(v.exp_keep);
      send_word(v.vld, v.tag, v.ch, v.rise, v.keep);
      check($sformatf("tbl%0d_tvalid", k), m_axis_tvalid, v.vld);
      check($sformatf("tbl%0d_tkeep", k), m_axis_tkeep, exp_q.pop_front());
      check($sformatf("tbl%0d_run_done", k), run_done, v.exp_rd);
      check($sformatf("tbl%0d_state", k), dbg_state, v.exp_state);
      check($sformatf("tbl%0d_active", k), acq_active, v.exp_state == 2'd2);
      check($sformatf("tbl%0d_tagtime", k), m_axis_tagtime, v.tag);
      check($sformatf("tbl%0d_channel", k), m_axis_channel, v.ch);
      check($sformatf("tbl%0d_rising", k), m_axis_rising_edge, v.rise);
    end
    wb_read_check("tbl_status", REG_STATUS, 32'h0002_0003);

    // Wrap-around window: t_start = 2^64-100, duration 300
    wb_write(REG_DUR_LO, 32'd300);
    wb_write(REG_NUM_RUNS, 32'd0);
    wb_write(REG_CTRL, 32'h1);
    wb_read_check("wrap_arm_status", REG_STATUS, 32'h0000_0001);
    send_word(1'b1, tags(64'hFFFF_FFFF_FFFF_FF9C, 0, 0, 0), chs(2, 0, 0, 0), 4'b0001, 4'b0001);
    word_check("wrap_trig", 4'b0001, 1'b0, ST_RUNNING);
    check("wrap_active", acq_active, 1'b1);
    send_word(1'b1, tags(150, 200, 0, 0), chs(0, 0, 0, 0), 4'b0011, 4'b0011);
    word_check("wrap_end", 4'b0001, 1'b1, ST_ARMED);

    // Three runs then DONE; ARM is ignored in ARMED so abort first
    wb_write(REG_CTRL, 32'h2);
    check("abort_armed_state", dbg_state, ST_IDLE);
    wb_write(REG_DUR_LO, 32'd10);
    wb_write(REG_NUM_RUNS, 32'd3);
    wb_write(REG_CTRL, 32'h1);
    wb_read_check("multi_arm_status", REG_STATUS, 32'h0000_0001);
    for (int k = 1; k <= 3; k++) begin
      send_word(1'b1, tags(k * 1000, k * 1000 + 5, k * 1000 + 10, k * 1000 + 11),
                chs(2, 0, 0, 2), 4'b1001, 4'b1111);
      word_check($sformatf("multi_run%0d", k), 4'b0011, 1'b1, (k == 3) ? ST_DONE : ST_ARMED);
    end
    wb_read_check("multi_status", REG_STATUS, 32'h0003_0003);
    send_word(1'b1, tags(5000, 0, 0, 0), chs(2, 0, 0, 0), 4'b0001, 4'b0001);
    word_check("multi_fourth", 4'b0000, 1'b0, ST_DONE);

    // ABORT during RUNNING keeps runs_done; ARM while RUNNING is ignored
    wb_write(REG_CTRL, 32'h2);
    wb_write(REG_DUR_LO, 32'd1000);
    wb_write(REG_NUM_RUNS, 32'd0);
    wb_write(REG_CTRL, 32'h1);
    send_word(1'b1, tags(100, 2000, 0, 0), chs(2, 0, 0, 0), 4'b0001, 4'b0011);
    word_check("abort_run1", 4'b0001, 1'b1, ST_ARMED);
    send_word(1'b1, tags(3000, 0, 0, 0), chs(2, 0, 0, 0), 4'b0001, 4'b0001);
    word_check("abort_trig", 4'b0001, 1'b0, ST_RUNNING);
    wb_write(REG_CTRL, 32'h1);
    wb_read_check("arm_in_running_status", REG_STATUS, 32'h0001_0002);
    wb_write(REG_CTRL, 32'h2);
    send_word(1'b1, tags(3010, 0, 0, 0), chs(0, 0, 0, 0), 4'b0001, 4'b0001);
    word_check("abort_after", 4'b0000, 1'b0, ST_IDLE);
    check("abort_active", acq_active, 1'b0);
    wb_read_check("abort_status", REG_STATUS, 32'h0001_0000);

    // Zero duration: trigger dropped, run counted at once, no retrigger
    wb_write(REG_DUR_LO, 32'd0);
    wb_write(REG_CTRL, 32'h1);
    send_word(1'b1, tags(500, 500, 600, 0), chs(2, 0, 2, 0), 4'b0101, 4'b0111);
    word_check("dur0", 4'b0000, 1'b1, ST_ARMED);
    wb_read_check("dur0_status", REG_STATUS, 32'h0001_0001);

`ifndef ACQ_WINDOW_STATS_EN
    wb_read_check("passed_absent", REG_PASSED, 32'h0);
    wb_read_check("dropped_absent", REG_DROPPED, 32'h0);
`endif

    // Asynchronous reset in the middle of a window
    wb_write(REG_DUR_LO, 32'd1000);
    send_word(1'b1, tags(700, 0, 0, 0), chs(2, 0, 0, 0), 4'b0001, 4'b0001);
    word_check("rstmid_trig", 4'b0001, 1'b0, ST_RUNNING);
    #2 rst = 1'b1;
    #1;
    check("rstmid_m_tvalid", m_axis_tvalid, 1'b0);
    check("rstmid_m_tkeep", m_axis_tkeep, 4'b0000);
    check("rstmid_active", acq_active, 1'b0);
    check("rstmid_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_run_done", run_done, 1'b0);
    wb_read_check("rstmid_status", REG_STATUS, 32'h0);
    wb_read_check("rstmid_dur_lo", REG_DUR_LO, 32'h0);
    wb_read_check("rstmid_config", REG_CONFIG, 32'h0);
    send_word(1'b1, tags(800, 0, 0, 0), chs(2, 0, 0, 0), 4'b0001, 4'b0001);
    word_check("rstmid_after", 4'b0000, 1'b0, ST_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/acq_window_ctrl.md
# acq_window_ctrl

Acquisition sequencer between the tag-stream input of `measurement` and the user measurement modules. It arms on a Wishbone command and triggers on a configured start channel/edge. It then forwards only events whose tag time lies inside a programmable window, repeats for a programmed number of runs, and ends in DONE. Downstream modules see an ordinary WORD_WIDTH-lane stream whose `tkeep` has been masked by the controller.

## Interface
- `WORD_WIDTH`, 4, number of event lanes per word
- `clk`  in  1  sole clock
- `rst`  in  1  reset; asynchronous, active-high
- `s_axis_tvalid`  in  1  input word valid
- `s_axis_tready`  out  1  equals `m_axis_tready`
- `s_axis_tagtime`  in  64×WORD_WIDTH  tag time, 1/3 ps units
- `s_axis_channel`  in  5×WORD_WIDTH  channel, 0-based
- `s_axis_rising_edge`  in  1×WORD_WIDTH  1 = rising edge
- `s_axis_tkeep`  in  WORD_WIDTH  per-lane event valid
- `m_axis_*`  out  same widths as `s_axis_*`  registered, masked copy of the input; `m_axis_tready` is an input
- `wb`  wb_interface.slave  —  register access
- `acq_active`  out  1  high while in RUNNING
- `run_done`  out  1  one-cycle pulse at the end of each window

## Operation
- Registers are 32-bit and word-aligned:
  - 0x00 CTRL (write-only pulses): bit0 ARM, bit1 ABORT.
  - 0x04 STATUS (read-only): [1:0] state; [31:16] runs_done.
  - 0x08 CONFIG: [4:0] start_channel; [8] start_rising.
  - 0x0C NUM_RUNS: [15:0]; 0 means infinite.
  - 0x10 / 0x14 DURATION_LO / DURATION_HI.
- State machine: IDLE=0, ARMED=1, RUNNING=2, DONE=3.
- IDLE/DONE + ARM → ARMED, and runs_done is cleared. ARM in ARMED or RUNNING is ignored.
- ARMED → RUNNING on the first valid lane (in lane order) whose channel = start_channel and edge = start_rising:
  - t_start is that lane's tagtime.
  - t_end = t_start + duration, modulo 2^64.
- In RUNNING, a lane passes iff its tkeep=1 and t_start ≤ tagtime < t_end. Comparisons are unsigned 64-bit on (tagtime − t_start) < duration, so wrap-around is handled.
- Trigger lane handling:
  - The trigger lane itself passes when duration > 0.
  - Later lanes in the same word are judged against the new window.
  - Earlier lanes in that word are dropped.
- End of window: the first valid lane with (tagtime − t_start) ≥ duration ends the window. That lane and all later lanes in the word are dropped.
  - runs_done increments, saturating at 0xFFFF, and `run_done` pulses.
  - Next state is ARMED, or DONE if runs_done reaches NUM_RUNS and NUM_RUNS ≠ 0.
- Duration 0: the trigger lane is dropped, the run is counted immediately, and the state goes to ARMED or DONE.
- A trigger is recognized at most once per word. A start event in the same word as a window end is not a trigger.
- ABORT moves any state to IDLE and leaves runs_done unchanged.
- In IDLE, ARMED and DONE, all output lanes have tkeep=0. `m_axis_tvalid` still follows `s_axis_tvalid`.

## Timing
- Stream latency is exactly 1 cycle. The output registers advance only when `m_axis_tready`=1.
- Wishbone ack is asserted one cycle after cyc&stb, with no wait states.
- A register write commits on its ack edge. A stream word accepted on that same edge uses the pre-write state and configuration.
- Reset values:
  - `m_axis_tvalid`=0, `m_axis_tkeep`=0, other `m_axis_*`=0.
  - `acq_active`=0, `run_done`=0.
  - state IDLE, all registers 0, runs_done 0.
- Reset mid-window drops the window immediately, and no `run_done` pulse is produced.
- CONFIG and DURATION are sampled at the trigger. Writes during RUNNING affect only the next run.

## Configuration
- `ACQ_WINDOW_STATS_EN` defined: adds two 32-bit wrapping counters.
  - PASSED (0x18): lanes forwarded.
  - DROPPED (0x1C): valid lanes masked.
  - Both clear on ARM.
- `ACQ_WINDOW_STATS_EN` undefined: the counters are absent, and 0x18/0x1C read 0.

## Structure
- `acq_window_pkg` contains:
  - the state enum;
  - the register offset constants;
  - the CTRL/CONFIG bit-position constants.
- Sub-module `acq_window_regs` holds the Wishbone register file and ARM/ABORT pulse generation. The top level holds the FSM and the lane masking.

## Test plan
- NUM_RUNS=1, duration=1000, start ch 2 rising; event on ch2 at t=5000, then t=5500 and t=6000 → the 5000 and 5500 events pass; 6000 is dropped; one `run_done` pulse; state DONE.
- One word with lanes {ch0@100, ch2↑@200, ch1@300, ch1@1300}, duration=1000 → output tkeep=0b0110.
- t_start=2^64−100, duration=300, event at tagtime 150 → passes via wrap; event at 200 → dropped and ends the window.
- NUM_RUNS=3 → three triggers give three pulses, runs_done=3, state DONE; a fourth trigger is not forwarded.
- ABORT during RUNNING → the next word is fully masked, state IDLE; asserting rst mid-window clears everything to the reset values.
- Duration=0 → the trigger lane is dropped and `run_done` pulses in the trigger word's output cycle.
